regfile_wport_arb: RTL and testbench

REGFILE_WPORT_ARB -- requirements
Module: regfile_wport_arb

---
 rtl/regfile_wport_arb.sv | 100 ++++++++++
 tb/tb_regfile_wport_arb.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter: two requesters share one write port, round-robin on conflict.
// Optional conflict statistics counter is built when REGF_ARB_STATS_EN is defined.
module regfile_wport_arb #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_stall,
    input  logic              req0_valid,
    input  logic [4:0]        req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    input  logic [4:0]        req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              write,
    output logic [4:0]        writenum,
    output logic [DATA_W-1:0] write_data
`ifdef REGF_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    // Handshake: a requester holds valid, rd and data stable until it sees ready;
    // a transfer happens in the cycle where valid and ready are both high. Ready
    // never depends on anything registered here except prio, and is never buffered.
    logic              prio;
    logic              both_valid;
    logic              xfer0;
    logic              xfer1;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;

    assign both_valid = req0_valid && req1_valid;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && !wb_stall) begin
            if (both_valid) begin
                req0_ready = !prio;
                req1_ready = prio;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    always_comb begin
        sel_rd   = req0_rd;
        sel_data = req0_data;
        if (xfer1) begin
            sel_rd   = req1_rd;
            sel_data = req1_data;
        end
    end

    // prio points at the requester that wins the next conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (xfer0) begin
            prio <= 1'b1;
        end else if (xfer1) begin
            prio <= 1'b0;
        end
    end

    // Writes to x0 are accepted but suppressed; index/data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            write      <= 1'b0;
            writenum   <= 5'd0;
            write_data <= '0;
        end else begin
            write <= (xfer0 || xfer1) && (sel_rd != 5'd0);
            if ((xfer0 || xfer1) && (sel_rd != 5'd0)) begin
                writenum   <= sel_rd;
                write_data <= sel_data;
            end
        end
    end

`ifdef REGF_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= 16'd0;
        end else if (both_valid && !wb_stall && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench for regfile_wport_arb: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_regfile_wport_arb;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_stall;
    logic              req0_valid;
    logic [4:0]        req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic [4:0]        req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              req0_ready;
    logic              req1_ready;
    logic              write;
    logic [4:0]        writenum;
    logic [DATA_W-1:0] write_data;
`ifdef REGF_ARB_STATS_EN
    logic [15:0]       conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: which requester wins the next conflict, and expected write port.
    int                mdl_favoured;
    logic              exp_write;
    logic [4:0]        exp_num;
    logic [DATA_W-1:0] exp_data;

    always #5 clk = ~clk;

    regfile_wport_arb #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_stall   (wb_stall),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .write      (write),
        .writenum   (writenum),
        .write_data (write_data)
`ifdef REGF_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v0, input logic [4:0] rd0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [DATA_W-1:0] d1,
                         input logic stall);
        req0_valid = v0;
        req0_rd    = rd0;
        req0_data  = d0;
        req1_valid = v1;
        req1_rd    = rd1;
        req1_data  = d1;
        wb_stall   = stall;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        mdl_favoured = 0;
        exp_write    = 1'b0;
        exp_num      = 5'd0;
        exp_data     = '0;
    endtask

    // Which requester should be granted given the current inputs.
    function automatic int model_winner();
        if (rst || wb_stall) return -1;
        if (req0_valid && req1_valid) return mdl_favoured;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // Apply one transfer (or none) to the model's view of the write port.
    task automatic model_commit(input int winner);
        exp_write = 1'b0;
        if (winner == 0) begin
            mdl_favoured = 1;
            if (req0_rd != 5'd0) begin
                exp_write = 1'b1;
                exp_num   = req0_rd;
                exp_data  = req0_data;
            end
        end else if (winner == 1) begin
            mdl_favoured = 0;
            if (req1_rd != 5'd0) begin
                exp_write = 1'b1;
                exp_num   = req1_rd;
                exp_data  = req1_data;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222, 1'b0);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({write, writenum, write_data} !== {1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got write=%b num=%0d data=%h expected 0 0 0",
                     write, writenum, write_data);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
        checks++;
        if ({write, writenum, write_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_write: got write=%b num=%0d data=%h expected 1 5 deadbeef",
                     write, writenum, write_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({write, writenum, write_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_hold: got write=%b num=%0d data=%h expected 0 5 deadbeef",
                     write, writenum, write_data);
        end
    endtask

    task automatic test_alternate();
        apply_reset();
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alternate_grant[%0d]: got %b expected %b", i,
                         {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({write, writenum} !== {1'b1, (i % 2 == 0) ? 5'd1 : 5'd2}) begin
                errors++;
                $display("FAIL alternate_writenum[%0d]: got write=%b num=%0d expected 1 %0d", i,
                         write, writenum, (i % 2 == 0) ? 1 : 2);
            end
        end
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    endtask

    task automatic test_rd_zero();
        apply_reset();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, '0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h1234, 1'b0);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rd0_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({write, writenum, write_data} !== {1'b0, 5'd3, 32'h33}) begin
            errors++;
            $display("FAIL rd0_write: got write=%b num=%0d data=%h expected 0 3 33",
                     write, writenum, write_data);
        end
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 1'b0);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rd0_prio: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    endtask

    task automatic test_stall();
        apply_reset();
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, '0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 5'd4, 32'h45, 1'b1, 5'd6, 32'h66, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready});
            end
            @(posedge clk);
            #1;
            if (i > 0) begin
                checks++;
                if (write !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_write[%0d]: got %b expected 0", i, write);
                end
            end
        end
        wb_stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release: got %b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
        checks++;
        if ({write, writenum, write_data} !== {1'b1, 5'd6, 32'h66}) begin
            errors++;
            $display("FAIL stall_release_write: got write=%b num=%0d data=%h expected 1 6 66",
                     write, writenum, write_data);
        end
    endtask

    task automatic test_same_rd();
        apply_reset();
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        checks++;
        if ({write, writenum, write_data} !== {1'b1, 5'd7, 32'hA}) begin
            errors++;
            $display("FAIL same_rd_first: got write=%b num=%0d data=%h expected 1 7 a",
                     write, writenum, write_data);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
        checks++;
        if ({write, writenum, write_data} !== {1'b1, 5'd7, 32'hB}) begin
            errors++;
            $display("FAIL same_rd_second: got write=%b num=%0d data=%h expected 1 7 b",
                     write, writenum, write_data);
        end
    endtask

    task automatic test_reset_drop();
        apply_reset();
        drive(1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, '0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({write, writenum, write_data} !== {1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_drop: got write=%b num=%0d data=%h expected 0 0 0",
                     write, writenum, write_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic              p0v, p1v;
        logic [4:0]        p0rd, p1rd;
        logic [DATA_W-1:0] p0d, p1d;
        logic              stall;
        int                winner;
        int                wait0, wait1;
        apply_reset();
        p0v = 1'b0;
        p1v = 1'b0;
        p0rd = '0;
        p1rd = '0;
        p0d = '0;
        p1d = '0;
        wait0 = 0;
        wait1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!p0v) begin
                p0v  = ($urandom_range(0, 2) != 0);
                p0rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                p0d  = $urandom;
            end
            if (!p1v) begin
                p1v  = ($urandom_range(0, 2) != 0);
                p1rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                p1d  = $urandom;
            end
            stall = ($urandom_range(0, 4) == 0);
            drive(p0v, p0rd, p0d, p1v, p1rd, p1d, stall);
            @(negedge clk);
            winner = model_winner();
            checks++;
            if ({req0_ready, req1_ready} !== {winner == 0, winner == 1}) begin
                errors++;
                $display("FAIL random_grant[%0d]: got %b expected %b", i,
                         {req0_ready, req1_ready}, {winner == 0, winner == 1});
            end
            if (p0v && !stall && !req0_ready) wait0++;
            if (p1v && !stall && !req1_ready) wait1++;
            checks++;
            if (wait0 > 1 || wait1 > 1) begin
                errors++;
                $display("FAIL random_starve[%0d]: got waits %0d/%0d expected at most 1", i,
                         wait0, wait1);
            end
            if (req0_ready) begin
                p0v = 1'b0;
                wait0 = 0;
            end
            if (req1_ready) begin
                p1v = 1'b0;
                wait1 = 0;
            end
            @(posedge clk);
            model_commit(winner);
            #1;
            checks++;
            if ({write, writenum, write_data} !== {exp_write, exp_num, exp_data}) begin
                errors++;
                $display("FAIL random_write[%0d]: got write=%b num=%0d data=%h expected %b %0d %h",
                         i, write, writenum, write_data, exp_write, exp_num, exp_data);
            end
        end
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    endtask

`ifdef REGF_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (conflict_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stats_count: got %0d expected 10", conflict_cnt);
        end
        repeat (69990) @(posedge clk);
        #1;
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_saturate: got %h expected ffff", conflict_cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
        checks++;
        if ({conflict_cnt, write} !== {16'd0, 1'b0}) begin
            errors++;
            $display("FAIL stats_reset: got cnt=%h write=%b expected 0 0", conflict_cnt, write);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_rd_zero();
        test_stall();
        test_same_rd();
        test_reset_drop();
        test_random();
`ifdef REGF_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
